// File: rtl/tdc_capture.sv
// Delay-line readout: registers the sensor taps every clock, decodes each
// thermometer snapshot to a tap count, and on request summarises a burst.
module tdc_capture #(
  parameter int N_TAPS       = 16,
  parameter int LOG2_SAMPLES = 4,
  parameter int CODE_W       = $clog2(N_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TAPS-1:0] taps,
  input  logic              start,
  input  logic              ack,
  output logic [CODE_W-1:0] code_now,
  output logic              busy,
  output logic              result_valid,
  output logic [CODE_W-1:0] avg,
  output logic [CODE_W-1:0] min_code,
  output logic [CODE_W-1:0] max_code,
  output logic [7:0]        bubble_cnt
);

  localparam int SUM_W = CODE_W + LOG2_SAMPLES;

  // Result handshake: result_valid stays high from the end of a burst until
  // the edge where ack is sampled high; results persist until the next burst.
  typedef enum logic [1:0] {IDLE, FILL, ACQ, DONE} state_e;

  state_e                  state_q;
  logic [N_TAPS-1:0]       taps_q;
  logic [CODE_W-1:0]       code_q;
  logic                    bub_q;
  logic [LOG2_SAMPLES-1:0] cnt_q;
  logic [SUM_W-1:0]        sum_q;
  logic [CODE_W-1:0]       min_q;
  logic [CODE_W-1:0]       max_q;
  logic [7:0]              bubbles_q;
  logic                    busy_q;
  logic                    valid_q;
  logic [CODE_W-1:0]       avg_q;
  logic [CODE_W-1:0]       min_code_q;
  logic [CODE_W-1:0]       max_code_q;
  logic [7:0]              bubble_cnt_q;

  logic [CODE_W-1:0] pop_d;
  logic              bubble_d;
  logic [SUM_W-1:0]  sum_d;
  logic [CODE_W-1:0] min_d;
  logic [CODE_W-1:0] max_d;
  logic [7:0]        bubbles_d;

  // A clean thermometer word plus one is a power of two, so the AND is zero.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      pop_d = pop_d + CODE_W'(taps_q[i]);
    end
    bubble_d = (taps_q & (taps_q + N_TAPS'(1))) != '0;
  end

  always_comb begin
    sum_d     = sum_q + SUM_W'(code_q);
    min_d     = (code_q < min_q) ? code_q : min_q;
    max_d     = (code_q > max_q) ? code_q : max_q;
    bubbles_d = (bub_q && bubbles_q != 8'hFF) ? bubbles_q + 8'd1 : bubbles_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      taps_q       <= '0;
      code_q       <= '0;
      bub_q        <= 1'b0;
      cnt_q        <= '0;
      sum_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      bubbles_q    <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      avg_q        <= '0;
      min_code_q   <= '0;
      max_code_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      taps_q <= taps;
      code_q <= pop_d;
      bub_q  <= bubble_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FILL;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            bubbles_q <= '0;
          end
        end
        FILL: state_q <= ACQ;
        ACQ: begin
          sum_q     <= sum_d;
          min_q     <= min_d;
          max_q     <= max_d;
          bubbles_q <= bubbles_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == {LOG2_SAMPLES{1'b1}}) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b1;
            avg_q        <= sum_d[SUM_W-1:LOG2_SAMPLES];
            min_code_q   <= min_d;
            max_code_q   <= max_d;
            bubble_cnt_q <= bubbles_d;
          end
        end
        DONE: begin
          if (ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code_now     = code_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign avg          = avg_q;
  assign min_code     = min_code_q;
  assign max_code     = max_code_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: doc/tdc_capture.md
Name: tdc_capture

Overview:
- Read-side companion to the inverter-chain delay sensor.
- Registers the sensor's tapped delay-line outputs every clock and decodes each thermometer snapshot into a tap count.
- On request, measures a burst of 2^LOG2_SAMPLES snapshots and reports average, min, max and bubble (non-thermometer) count through a valid/ack handshake.
- Sits between the sensor instance and the top-level output mux.

Parameters:
N_TAPS, 16, number of delay-line taps sampled (taps[0] = first stage).
LOG2_SAMPLES, 4, log2 of snapshots per measurement (burst = 16 by default).
CODE_W, $clog2(N_TAPS+1), derived; width of one decoded code (5 for 16 taps).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
taps  input  N_TAPS  raw delay-line tap levels from the sensor
start  input  1  request one measurement burst (level, sampled each edge)
ack  input  1  consumer acknowledges the result
code_now  output  CODE_W  live decoded code (popcount of last captured snapshot)
busy  output  1  high in FILL and ACQ
result_valid  output  1  high in DONE
avg  output  CODE_W  sum of burst codes >> LOG2_SAMPLES (truncating)
min_code  output  CODE_W  smallest code in burst
max_code  output  CODE_W  largest code in burst
bubble_cnt  output  8  snapshots in burst that were not clean thermometer codes, saturating at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; taps_q, code_q, accumulators and all outputs are 0.
- Capture pipeline runs every cycle, independent of FSM state:
  - Stage 1: taps_q <= taps.
  - Stage 2: code_q <= popcount(taps_q); bub_q <= ((taps_q & (taps_q + 1)) != 0).
  - code_now = code_q; latency 2 edges from taps to code_now.
- Clean thermometer means ones are contiguous from bit 0 (e.g. 0x00FF, 0x0000, 0xFFFF). Bubbled codes still contribute their popcount.
- FSM:
  - IDLE: start=1 -> FILL at edge E0; accumulators cleared (sum=0, min=all-ones, max=0, bubbles=0).
  - FILL: one cycle -> ACQ at edge E1.
  - ACQ: edges E2..E(1+2^L) each add code_q to sum, update min/max, and increment bubbles if bub_q (saturating). A sample counter of width LOG2_SAMPLES counts accepted samples.
  - Samples consumed are exactly the taps values present at edges E0..E(2^L-1).
  - ACQ last sample at edge E(1+2^L): final accumulate and register avg/min_code/max_code/bubble_cnt in the same edge -> DONE.
  - DONE: result_valid=1; outputs held. ack=1 -> IDLE; result_valid falls after that edge.
- Result outputs keep the last completed measurement after ack and are overwritten only at the next ACQ->DONE. Their value is 0 before the first measurement.
- Sum width is CODE_W+LOG2_SAMPLES; it cannot overflow.
- start is ignored in FILL/ACQ/DONE. start and ack together in DONE: ack honoured, start dropped; the requester re-asserts start in IDLE.
- start held high continuously gives back-to-back bursts, separated by the one DONE cycle in which ack is seen plus the IDLE cycle.
- ack outside DONE is ignored.
- rst mid-burst aborts immediately to IDLE with all outputs 0; no partial result is reported.
- Input taps are asynchronous to clk by design (that is the measurement). Stage-1 flops may go metastable; no synchroniser is added, and bubbles count this effect.

Test Plan:
- Reset: rst=1 mid-ACQ with taps=0x0FFF -> after one edge busy=0, result_valid=0, avg/min/max/bubble_cnt=0, code_now=0.
- Constant clean code: taps=0x00FF, start pulse at E0 -> busy from E0, result_valid rises exactly at E17; avg=8, min=8, max=8, bubble_cnt=0; code_now=8.
- Alternating codes: taps toggles 0x000F/0x0FFF each cycle from E0 -> avg=8 ((8*4+8*12)/16), min=4, max=12, bubble_cnt=0.
- Bubbles: taps=0x00F7 (popcount 7, non-thermometer) for whole burst -> avg=7, min=max=7, bubble_cnt=16; then taps=0xFFFF -> code_now=16 two edges later.
- Handshake: in DONE, hold ack=0 for 10 cycles -> outputs stable, start ignored. Then ack=1 together with start=1 -> IDLE, result_valid=0, no new burst. Then start=1 -> new burst begins.
- Extremes: taps=0x0000 burst -> avg=min=max=0. taps=0xFFFF burst -> avg=min=max=16, sum=256, no overflow.
